flitzip_bit_packer: RTL

// - Downstream of the FlitZip compressor. Accepts variable-length compressed

---
 rtl/flitzip_pkg.sv | 21 ++
 rtl/flitzip_lsb_mask.sv | 12 +
 rtl/flitzip_bit_packer.sv | 109 ++++++++++
 3 files changed

// File: rtl/flitzip_pkg.sv
// FlitZip shared widths and helpers.
// Used by the compressor, the packer and the unpacker.
package flitzip_pkg;

  localparam int FLIT_W     = 128;
  localparam int CHUNK_SIZE = 8;
  localparam int LEN_W      = $clog2(FLIT_W) + 1;
  localparam int CNT_W      = 16;
  localparam int BUF_W      = 2 * FLIT_W;
  localparam int BCNT_W     = $clog2(BUF_W) + 1;

  localparam logic [LEN_W-1:0]  LEN_FULL = LEN_W'(FLIT_W);
  localparam logic [BCNT_W-1:0] CNT_FULL = BCNT_W'(FLIT_W);

  function automatic logic len_legal(
    input logic [LEN_W-1:0] len
  );
    return (len != '0) && (len <= LEN_FULL);
  endfunction

endpackage

// File: rtl/flitzip_lsb_mask.sv
// LSB mask generator: len ones from bit 0 upward.
// len >= FLIT_W yields an all-ones mask.
module flitzip_lsb_mask
  import flitzip_pkg::*;
(
  input  logic [LEN_W-1:0]  len,
  output logic [FLIT_W-1:0] mask
);

  assign mask = ~({FLIT_W{1'b1}} << len);

endmodule

// File: rtl/flitzip_bit_packer.sv
// FlitZip bit packer: packs variable-length flits
// back-to-back into FLIT_W-bit link words.
module flitzip_bit_packer
  import flitzip_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FLIT_W-1:0] in_data,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              flush_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FLIT_W-1:0] out_data,
  output logic              out_last,
  output logic              flush_done,
  output logic              err_len,
  output logic [CNT_W-1:0]  out_words
);

  logic [BUF_W-1:0]  pack_buf;
  logic [BCNT_W-1:0] cnt_q;
  logic              flush_pend_q;

  logic [LEN_W-1:0]  eff_len;
  logic [FLIT_W-1:0] len_mask;
  logic [FLIT_W-1:0] masked;
  logic              accept;
  logic              pop;
  logic              flush_act;
  logic [BCNT_W-1:0] cnt_pop;
  logic [BCNT_W-1:0] cnt_nxt;
  logic [BUF_W-1:0]  placed;
  logic [BUF_W-1:0]  buf_nxt;

  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign flush_act = flush_pend_q || flush_req;

  assign out_valid = (cnt_q >= CNT_FULL) ||
                     (flush_pend_q && cnt_q != '0);
  assign out_last  = flush_pend_q && cnt_q != '0 &&
                     cnt_q <= CNT_FULL;
  assign out_data  = pack_buf[FLIT_W-1:0];

  always_comb begin
    eff_len = in_len;
    unique case (1'b1)
      (in_len == '0):      eff_len = '0;
      (in_len > LEN_FULL): eff_len = LEN_FULL;
      default:             eff_len = in_len;
    endcase
  end

  flitzip_lsb_mask u_mask (
    .len  (eff_len),
    .mask (len_mask)
  );

  assign masked = in_data & len_mask;

  // Pop shifts first, so a same-cycle flit lands at cnt-FLIT_W.
  always_comb begin
    cnt_pop = cnt_q;
    if (pop) begin
      cnt_pop = (cnt_q > CNT_FULL) ? cnt_q - CNT_FULL : '0;
    end
    placed = '0;
    if (accept) begin
      placed = {{FLIT_W{1'b0}}, masked} << cnt_pop;
    end
    buf_nxt = pack_buf;
    if (pop) begin
      buf_nxt = {{FLIT_W{1'b0}}, pack_buf[BUF_W-1:FLIT_W]};
    end
    buf_nxt = buf_nxt | placed;
    cnt_nxt = cnt_pop;
    if (accept) begin
      cnt_nxt = cnt_pop + BCNT_W'(eff_len);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_buf     <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      flush_done   <= 1'b0;
      in_ready     <= 1'b0;
      err_len      <= 1'b0;
      out_words    <= '0;
    end else begin
      pack_buf     <= buf_nxt;
      cnt_q        <= cnt_nxt;
      flush_pend_q <= flush_act && cnt_nxt != '0;
      flush_done   <= flush_act && cnt_nxt == '0;
      in_ready     <= !(flush_act && cnt_nxt != '0) &&
                      cnt_nxt <= CNT_FULL;
      if (accept && !len_legal(in_len)) begin
        err_len <= 1'b1;
      end
      if (pop) begin
        out_words <= out_words + CNT_W'(1);
      end
    end
  end

endmodule
